// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the transmitter and the receiver.
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // s_tick pulses per bit period (16x oversampling)
    localparam int OVERSAMPLE = 16;
    localparam int DIN_W      = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side handshake and line signals between a frame source and uart_tx.
interface uart_tx_if;
    import uart_pkg::*;

    logic             s_tick;
    logic             tx_start;
    logic [DIN_W-1:0] din;
    logic             tx_busy;
    logic             tx_done_tick;
    logic             tx;

    modport master (
        output s_tick, tx_start, din,
        input  tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx_busy, tx_done_tick, tx
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, no parity, stop period
// of SB_TICK oversample ticks; paced by an external 16x s_tick enable.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave bus
);

    localparam int              NW        = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0]   N_LAST    = NW'(DBIT - 1);
    localparam logic [4:0]      S_LAST    = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      STOP_LAST = 5'(SB_TICK - 1);

    uart_state_t      state_reg, state_next;
    logic [4:0]       s_reg, s_next;
    logic [NW-1:0]    n_reg, n_next;
    logic [DIN_W-1:0] b_reg, b_next;
    logic             tx_reg, tx_next;
    logic             done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            tx_reg    <= tx_next;
        end
    end

    // tx_next follows the current state, so the line lags state entry by one cycle
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        tx_next    = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (bus.tx_start) begin
                    state_next = ST_START;
                    s_next     = '0;
                    b_next     = bus.din;
                end
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bus.s_tick) begin
                    if (s_reg == S_LAST) begin
                        state_next = ST_DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_DATA: begin
                tx_next = b_reg[0];
                if (bus.s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = ST_STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bus.s_tick) begin
                    if (s_reg == STOP_LAST) begin
                        state_next = ST_IDLE;
                        done       = 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.tx           = tx_reg;
    assign bus.tx_busy      = (state_reg != ST_IDLE);
    assign bus.tx_done_tick = done;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning the number of data bits per frame (legal range 5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning s_tick count for the stop period (16/24/32 = 1/1.5/2 stop bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port s_tick, input, 1 bit: one-cycle 16x-oversampling enable from the external baud tick generator.
REQ-006 The block SHALL have port tx_start, input, 1 bit: frame request, sampled only in IDLE.
REQ-007 The block SHALL have port din, input, 8 bits: frame data; bits [DBIT-1:0] are used.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port tx_done_tick, output, 1 bit: one-cycle pulse at frame end.
REQ-010 The block SHALL have port tx, output, 1 bit: registered serial line, idle-high.

Function
REQ-011 The block SHALL implement FSM states IDLE, START, DATA and STOP, with tick counter s_reg (5 bits), bit counter n_reg ($clog2(DBIT) bits), shift register b_reg (8 bits) and tx_reg.
REQ-012 In IDLE with tx_start=1, the block SHALL on the next edge load b_reg<=din, set s_reg<=0, and go to START; din is ignored afterwards.
REQ-013 tx_start while tx_busy=1 SHALL be ignored; no queuing.
REQ-014 tx SHALL be tx_reg, driven one cycle after state entry: 1 in IDLE/STOP, 0 in START, b_reg[0] in DATA.
REQ-015 Counters SHALL advance only on cycles with s_tick=1; without s_tick all state SHALL hold.
REQ-016 START: on s_tick with s_reg==15, the block SHALL set s_reg<=0, n_reg<=0 and go to DATA; otherwise on s_tick, s_reg+1.
REQ-017 DATA: on s_tick with s_reg==15, the block SHALL set s_reg<=0 and shift b_reg right by 1; if n_reg==DBIT-1 it SHALL go to STOP, else n_reg+1.
REQ-018 The block SHALL send data LSB first, DBIT bits, with no parity.
REQ-019 STOP: on s_tick with s_reg==SB_TICK-1, the block SHALL go to IDLE and assert tx_done_tick for exactly that one cycle (combinational from the transition).
REQ-020 With s_tick every cycle, the frame SHALL last (1+DBIT)*16+SB_TICK cycles of line time.
REQ-021 A tx_start coincident with tx_done_tick SHALL be ignored; a new frame is accepted no earlier than the cycle after return to IDLE.
REQ-022 s_tick=1 on the tx_start cycle SHALL NOT count toward START.

Reset
REQ-023 reset SHALL be synchronous and active-high, and SHALL take priority over all other inputs.
REQ-024 On reset the block SHALL set state=IDLE, s_reg=0, n_reg=0, b_reg=0 and tx_reg=1, so that tx=1, tx_busy=0 and tx_done_tick=0.
REQ-025 Reset mid-frame SHALL abort the frame: tx=1 from the following cycle, with no tx_done_tick.

Structure
REQ-026 The state encoding localparams and the oversample constant (16) SHALL live in shared package uart_pkg, for reuse by the receiver.
REQ-027 The block SHALL be a single module with no sub-module; the baud tick is generated externally and shared with the receiver.

Verification
REQ-028 Reset held for 3 cycles, then released -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
REQ-029 din=8'hA5, tx_start pulse, s_tick every cycle -> tx = 0, 1,0,1,0,0,1,0,1, 1, each level for 16 cycles, and tx_done_tick pulses once, 160 cycles after START entry.
REQ-030 s_tick every 4th cycle, din=8'h3C -> each bit lasts 64 cycles and bit order is 0,0,1,1,1,1,0,0.
REQ-031 tx_start reasserted with din=8'hFF during DATA of an 8'h00 frame -> the frame stays 8'h00 and no second frame starts.
REQ-032 reset asserted in DATA bit 3 -> tx=1 and tx_busy=0 next cycle, no done pulse, and the next tx_start sends a full frame.
REQ-033 SB_TICK=32, DBIT=7, din=8'h55 -> 7 data bits 1,0,1,0,1,0,1, and stop lasts 32 ticks.
